// File: rtl/btb_update_sched_pkg.sv
// Shared types for the BTB update scheduler.
//   btb_upd_t     : one BTB update record {pc, target, is_jal, is_br, taken}
//   sched_state_t : scheduler mode {IDLE, SWEEP, DONE}
//   sat_add32     : 32-bit saturating add used by the optional perf counters
package btb_update_sched_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        is_jal;
        logic        is_br;
        logic        taken;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/btb_update_sched_fifo.sv
// btb_upd_fifo: synchronous in-order FIFO of BTB updates.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : drop all entries (takes priority over push/pop)
//   push[1:0]   : push enables; push_data[0] lands ahead of push_data[1]
//   pop         : remove head entry
//   head        : oldest entry (don't-care when empty)
//   count       : occupancy, one bit wider than the pointers
//   empty       : count == 0
// The caller guarantees no overflow and no pop when empty.
module btb_upd_fifo
    import btb_update_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic [1:0]                      push,
    input  btb_upd_t [1:0]                  push_data,
    input  logic                            pop,
    output btb_upd_t                        head,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    btb_upd_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic [CW-1:0]   n_push;

    assign n_push = CW'(push[0]) + CW'(push[1]);
    assign head   = mem[rptr];
    assign empty  = (count == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(pop);
            count <= count + n_push - CW'(pop);
        end
    end

    // A lone push on port 1 is compacted into the next free slot.
    always_ff @(posedge clk) begin
        if (!(rst || clear)) begin
            if (push == 2'b11) begin
                mem[wptr]            <= push_data[0];
                mem[wptr + AW'(1)]   <= push_data[1];
            end else if (push[0]) begin
                mem[wptr]            <= push_data[0];
            end else if (push[1]) begin
                mem[wptr]            <= push_data[1];
            end
        end
    end

endmodule

// File: rtl/btb_update_sched.sv
// btb_update_sched: schedules all writes into the BTB's single update port.
//   req_valid/req_ready/req_upd [1:0] : port 0 = ROB commit, port 1 = execute-stage resolution
//   upd_valid/upd_ready/upd           : head of the update queue toward the BTB
//   inv_req                           : start a full invalidate sweep (ignored unless idle)
//   inv_valid/inv_idx                 : per-entry invalidate strobe during the sweep
//   inv_done                          : one-cycle pulse after the last entry
//   lookup_block                      : fetch must ignore BTB predictions
// Optional macro BTB_UPD_PERF_EN adds saturating counters perf_enq, perf_drop_inv, perf_stall.
module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BTB_DEPTH  = 32,
    parameter int BTB_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  btb_upd_t [1:0]        req_upd,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output btb_upd_t              upd,
    input  logic                  inv_req,
    output logic                  inv_valid,
    output logic [BTB_IDX_W-1:0]  inv_idx,
    output logic                  inv_done,
    output logic                  lookup_block
`ifdef BTB_UPD_PERF_EN
    ,
    output logic [31:0]           perf_enq,
    output logic [31:0]           perf_drop_inv,
    output logic [31:0]           perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(BTB_DEPTH - 1);

    sched_state_t   state;
    logic           rr_ptr;
    logic           rr_flip;
    logic           idle;
    logic           start_inv;
    logic           pop;
    logic [1:0]     xfer;
    logic [1:0]     push;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic [CW:0]    free_slots;

    assign idle      = (state == IDLE);
    assign start_inv = idle && inv_req;

    // The head is withheld in the invalidate cycle so every pending entry is discarded.
    assign upd_valid = idle && !fifo_empty && !inv_req && !rst;
    assign pop       = upd_valid && upd_ready;

    // A slot freed by this cycle's dequeue is usable by this cycle's request.
    assign free_slots = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + (CW+1)'(pop);

    always_comb begin
        req_ready = '0;
        rr_flip   = 1'b0;
        if (idle && !inv_req && !rst) begin
            if (free_slots >= (CW+1)'(2)) begin
                req_ready = 2'b11;
            end else if (free_slots == (CW+1)'(1)) begin
                if (req_valid == 2'b11) begin
                    req_ready[rr_ptr] = 1'b1;
                    rr_flip           = 1'b1;
                end else begin
                    req_ready = 2'b11;
                end
            end
        end
    end

    assign xfer    = req_valid & req_ready;
    assign push[0] = xfer[0] && (req_upd[0].is_jal || req_upd[0].is_br);
    assign push[1] = xfer[1] && (req_upd[1].is_jal || req_upd[1].is_br);

    btb_upd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_inv),
        .push      (push),
        .push_data (req_upd),
        .pop       (pop),
        .head      (upd),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            inv_valid    <= 1'b0;
            inv_idx      <= '0;
            inv_done     <= 1'b0;
            lookup_block <= 1'b0;
        end else begin
            if (rr_flip)
                rr_ptr <= ~rr_ptr;
            unique case (state)
                IDLE: begin
                    if (inv_req) begin
                        state        <= SWEEP;
                        inv_valid    <= 1'b1;
                        inv_idx      <= '0;
                        lookup_block <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (inv_idx == LAST_IDX) begin
                        state     <= DONE;
                        inv_valid <= 1'b0;
                        inv_idx   <= '0;
                        inv_done  <= 1'b1;
                    end else begin
                        inv_idx <= inv_idx + BTB_IDX_W'(1);
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    inv_done     <= 1'b0;
                    lookup_block <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTB_UPD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_enq      <= '0;
            perf_drop_inv <= '0;
            perf_stall    <= '0;
        end else begin
            perf_enq <= sat_add32(perf_enq, 32'(push[0]) + 32'(push[1]));
            if (start_inv)
                perf_drop_inv <= sat_add32(perf_drop_inv, 32'(fifo_count));
            if (|(req_valid & ~req_ready))
                perf_stall <= sat_add32(perf_stall, 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;
    import btb_update_sched_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    btb_upd_t [1:0] req_upd;
    logic           upd_valid;
    logic           upd_ready;
    btb_upd_t       upd;
    logic           inv_req;
    logic           inv_valid;
    logic [4:0]     inv_idx;
    logic           inv_done;
    logic           lookup_block;
`ifdef BTB_UPD_PERF_EN
    logic [31:0]    perf_enq, perf_drop_inv, perf_stall;
`endif

    always #5 clk = ~clk;

    btb_update_sched #(
        .FIFO_DEPTH (4),
        .BTB_DEPTH  (32),
        .BTB_IDX_W  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_upd      (req_upd),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd          (upd),
        .inv_req      (inv_req),
        .inv_valid    (inv_valid),
        .inv_idx      (inv_idx),
        .inv_done     (inv_done),
        .lookup_block (lookup_block)
`ifdef BTB_UPD_PERF_EN
        ,
        .perf_enq      (perf_enq),
        .perf_drop_inv (perf_drop_inv),
        .perf_stall    (perf_stall)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of pending updates, round-robin bit, sweep position
    // (-1 idle, 0..31 sweeping entry, 32 done cycle).
    btb_upd_t q[$];
    bit       m_rr  = 1'b0;
    int       m_pos = -1;

    function automatic void chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    task automatic drive(input logic r, input logic [1:0] v,
                         input logic [31:0] p0, input logic b0,
                         input logic [31:0] p1, input logic b1,
                         input logic ur, input logic inv);
        rst        = r;
        req_valid  = v;
        req_upd[0] = '{pc: p0, target: p0 + 32'h40, is_jal: 1'b0, is_br: b0, taken: b0};
        req_upd[1] = '{pc: p1, target: p1 + 32'h40, is_jal: 1'b0, is_br: b1, taken: b1};
        upd_ready  = ur;
        inv_req    = inv;
    endtask

    // Compare every output against the model for the current inputs, then advance the model.
    task automatic model_step();
        bit         idle;
        logic       euv;
        int         free;
        logic [1:0] er;
        logic [1:0] acc;
        idle = (m_pos < 0);
        euv  = idle && (q.size() > 0) && !inv_req && !rst;
        free = 4 - q.size() + ((euv && upd_ready) ? 1 : 0);
        er   = 2'b00;
        if (idle && !inv_req && !rst) begin
            if (free >= 2)
                er = 2'b11;
            else if (free == 1)
                er = (req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : 2'b11;
        end
        chk("m_req_ready", 67'(req_ready), 67'(er));
        chk("m_upd_valid", 67'(upd_valid), 67'(euv));
        if (euv && upd_valid)
            chk("m_upd", upd, q[0]);
        chk("m_inv_valid", 67'(inv_valid), 67'(m_pos >= 0 && m_pos < 32));
        if (m_pos >= 0 && m_pos < 32)
            chk("m_inv_idx", 67'(inv_idx), 67'(m_pos));
        chk("m_inv_done", 67'(inv_done), 67'(m_pos == 32));
        chk("m_lookup_block", 67'(lookup_block), 67'(m_pos >= 0));

        if (rst) begin
            q.delete();
            m_rr  = 1'b0;
            m_pos = -1;
        end else begin
            if (euv && upd_ready)
                void'(q.pop_front());
            acc = req_valid & er;
            for (int i = 0; i < 2; i++)
                if (acc[i] && (req_upd[i].is_jal || req_upd[i].is_br))
                    q.push_back(req_upd[i]);
            if (req_valid == 2'b11 && $countones(acc) == 1)
                m_rr = ~acc[1];
            if (idle && inv_req) begin
                q.delete();
                m_pos = 0;
            end else if (m_pos >= 0 && m_pos < 32) begin
                m_pos++;
            end else if (m_pos == 32) begin
                m_pos = -1;
            end
        end
    endtask

    task automatic end_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  v;
        logic [31:0] p0;
        logic        b0;
        logic [31:0] p1;
        logic        b1;
        logic        ur;
        logic [1:0]  er;
        logic        euv;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t V(input logic r, input logic [1:0] v,
                               input logic [31:0] p0, input logic b0,
                               input logic [31:0] p1, input logic b1, input logic ur,
                               input logic [1:0] er, input logic euv, input logic [31:0] epc);
        V = '{r, v, p0, b0, p1, b1, ur, er, euv, epc};
    endfunction

    vec_t tbl[30];

    initial begin
        tbl[0]  = V(1, 2'b01, 32'h6000_0010, 1, 0, 0, 0, 2'b00, 0, 0);
        tbl[1]  = V(0, 2'b01, 32'h6000_0010, 1, 0, 0, 1, 2'b11, 0, 0);
        tbl[2]  = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h6000_0010);
        tbl[3]  = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0);
        tbl[4]  = V(0, 2'b11, 32'h100, 1, 32'h200, 1, 0, 2'b11, 0, 0);
        tbl[5]  = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h100);
        tbl[6]  = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h200);
        tbl[7]  = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0);
        tbl[8]  = V(0, 2'b01, 32'h300, 1, 0, 0, 0, 2'b11, 0, 0);
        tbl[9]  = V(0, 2'b01, 32'h304, 1, 0, 0, 0, 2'b11, 1, 32'h300);
        tbl[10] = V(0, 2'b01, 32'h308, 1, 0, 0, 0, 2'b11, 1, 32'h300);
        tbl[11] = V(0, 2'b01, 32'h30C, 1, 0, 0, 0, 2'b11, 1, 32'h300);
        tbl[12] = V(0, 2'b01, 32'h310, 1, 0, 0, 0, 2'b00, 1, 32'h300);
        tbl[13] = V(0, 2'b01, 32'h310, 1, 0, 0, 1, 2'b11, 1, 32'h300);
        tbl[14] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h304);
        tbl[15] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h308);
        tbl[16] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h30C);
        tbl[17] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h310);
        tbl[18] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0);
        tbl[19] = V(0, 2'b01, 32'h400, 1, 0, 0, 0, 2'b11, 0, 0);
        tbl[20] = V(0, 2'b11, 32'h404, 1, 32'h408, 1, 0, 2'b11, 1, 32'h400);
        tbl[21] = V(0, 2'b11, 32'h40C, 1, 32'h500, 1, 0, 2'b01, 1, 32'h400);
        tbl[22] = V(0, 2'b11, 32'h410, 1, 32'h500, 1, 1, 2'b10, 1, 32'h400);
        tbl[23] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h404);
        tbl[24] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h408);
        tbl[25] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h40C);
        tbl[26] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 1, 32'h500);
        tbl[27] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0);
        tbl[28] = V(0, 2'b01, 32'h700, 0, 0, 0, 1, 2'b11, 0, 0);
        tbl[29] = V(0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0);

        // Initial reset edge; register contents before it are undefined.
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Directed table: basic flow, dual push order, full/backpressure, round-robin, discard.
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].p0, tbl[i].b0, tbl[i].p1, tbl[i].b1, tbl[i].ur, 1'b0);
            @(negedge clk);
            chk($sformatf("t%0d_req_ready", i), 67'(req_ready), 67'(tbl[i].er));
            chk($sformatf("t%0d_upd_valid", i), 67'(upd_valid), 67'(tbl[i].euv));
            if (tbl[i].euv)
                chk($sformatf("t%0d_upd_pc", i), 67'(upd.pc), 67'(tbl[i].epc));
            end_cycle();
        end

        // Invalidate with 3 pending entries.
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b01, 32'h800 + 32'(i * 4), 1, 0, 0, 0, 0);
            @(negedge clk);
            end_cycle();
        end
        drive(0, 2'b11, 32'h900, 1, 32'h904, 1, 1, 1);
        @(negedge clk);
        chk("inv_start_req_ready", 67'(req_ready), 67'(2'b00));
        end_cycle();
        for (int k = 0; k < 32; k++) begin
            drive(0, 2'b11, 32'h900, 1, 32'h904, 1, 1, (k % 5) == 0);
            @(negedge clk);
            chk("sweep_inv_valid", 67'(inv_valid), 67'(1));
            chk("sweep_inv_idx", 67'(inv_idx), 67'(k));
            chk("sweep_lookup_block", 67'(lookup_block), 67'(1));
            chk("sweep_upd_valid", 67'(upd_valid), 67'(0));
            chk("sweep_req_ready", 67'(req_ready), 67'(2'b00));
            end_cycle();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("done_inv_done", 67'(inv_done), 67'(1));
        chk("done_lookup_block", 67'(lookup_block), 67'(1));
        chk("done_inv_valid", 67'(inv_valid), 67'(0));
        end_cycle();
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("post_inv_done", 67'(inv_done), 67'(0));
        chk("post_lookup_block", 67'(lookup_block), 67'(0));
        chk("post_inv_valid", 67'(inv_valid), 67'(0));
        chk("post_upd_valid", 67'(upd_valid), 67'(0));
        end_cycle();

        // Reset in the middle of a sweep.
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b01, 32'hA00 + 32'(i * 4), 1, 0, 0, 0, 0);
            @(negedge clk);
            end_cycle();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        end_cycle();
        for (int k = 0; k <= 10; k++) begin
            drive(k == 10, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("rst_sweep_inv_idx", 67'(inv_idx), 67'(k));
            end_cycle();
        end
        drive(0, 2'b01, 32'h6000_0010, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk("after_rst_inv_valid", 67'(inv_valid), 67'(0));
        chk("after_rst_inv_idx", 67'(inv_idx), 67'(0));
        chk("after_rst_inv_done", 67'(inv_done), 67'(0));
        chk("after_rst_lookup_block", 67'(lookup_block), 67'(0));
        chk("after_rst_upd_valid", 67'(upd_valid), 67'(0));
        chk("after_rst_req_ready", 67'(req_ready), 67'(2'b11));
        end_cycle();
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("after_rst_push_valid", 67'(upd_valid), 67'(1));
        chk("after_rst_push_pc", 67'(upd.pc), 67'(32'h6000_0010));
        chk("after_rst_push_tgt", 67'(upd.target), 67'(32'h6000_0050));
        end_cycle();
        for (int k = 0; k < 40; k++) begin
            drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            end_cycle();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            inv_req   = ($urandom_range(0, 79) == 0);
            req_valid = 2'($urandom);
            upd_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 2; i++)
                req_upd[i] = '{pc: $urandom, target: $urandom, is_jal: 1'($urandom),
                               is_br: 1'($urandom), taken: 1'($urandom)};
            @(negedge clk);
            end_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
